// File: rtl/cv32e40x_div_seq.sv
// Sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional build macro DIV_EARLY_OUT_EN skips the leading zero bits of |a| to shorten the iteration count.
module cv32e40x_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [1:0]  operator_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        kill_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o
);

  localparam logic [1:0] DIV_DIV  = 2'd0;
  localparam logic [1:0] DIV_DIVU = 2'd1;
  localparam logic [1:0] DIV_REM  = 2'd2;
  localparam logic [1:0] DIV_REMU = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_reg, state_next;
  logic [32:0] rem_reg, rem_next;
  logic [31:0] quo_reg, quo_next;
  logic [31:0] div_reg, div_next;
  logic [5:0]  cnt_reg, cnt_next;
  logic        neg_q_reg, neg_q_next;
  logic        neg_r_reg, neg_r_next;
  logic        is_rem_reg, is_rem_next;
  logic [31:0] result_reg, result_next;

  // Operand decode and magnitude extraction
  logic        op_signed, op_rem;
  logic [32:0] a_ext, b_ext, abs_a33, abs_b33;
  logic [31:0] abs_a, abs_b;
  logic        b_zero, sign_ovf, accept;
  logic        abs_unused;

  assign op_signed = (operator_i == DIV_DIV) || (operator_i == DIV_REM);
  assign op_rem    = (operator_i == DIV_REM) || (operator_i == DIV_REMU);
  assign a_ext     = {op_signed & op_a_i[31], op_a_i};
  assign b_ext     = {op_signed & op_b_i[31], op_b_i};
  assign abs_a33   = a_ext[32] ? (33'd0 - a_ext) : a_ext;
  assign abs_b33   = b_ext[32] ? (33'd0 - b_ext) : b_ext;
  // A 33-bit magnitude of a 32-bit operand never sets bit 32.
  assign abs_a      = abs_a33[31:0];
  assign abs_b      = abs_b33[31:0];
  assign abs_unused = abs_a33[32] ^ abs_b33[32];

  assign b_zero   = (op_b_i == 32'd0);
  assign sign_ovf = op_signed && (op_a_i == 32'h8000_0000) && (op_b_i == 32'hFFFF_FFFF);
  assign accept   = valid_i && (state_reg == IDLE) && !kill_i;

  logic [5:0]  iter_init;
  logic [31:0] dvd_init;

`ifdef DIV_EARLY_OUT_EN
  logic [5:0] clz;

  always_comb begin
    clz = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (abs_a[i]) clz = 6'(31 - i);
    end
  end

  // Zero dividend still needs one step so the normal completion path is taken.
  assign iter_init = (clz == 6'd32) ? 6'd1 : (6'd32 - clz);
  assign dvd_init  = abs_a << clz;
`else
  assign iter_init = 6'd32;
  assign dvd_init  = abs_a;
`endif

  // One restoring step: shift the dividend MSB into the partial remainder, subtract if it fits.
  logic [33:0] rem_shift, diff;
  logic        q_bit;
  logic [32:0] rem_step;
  logic [31:0] quo_step;
  logic [31:0] rem_fin, res_fin;

  assign rem_shift = {rem_reg, quo_reg[31]};
  assign diff      = rem_shift - {2'b00, div_reg};
  assign q_bit     = ~diff[33];
  assign rem_step  = q_bit ? diff[32:0] : rem_shift[32:0];
  assign quo_step  = {quo_reg[30:0], q_bit};
  assign rem_fin   = rem_step[31:0];
  assign res_fin   = is_rem_reg ? (neg_r_reg ? (32'd0 - rem_fin) : rem_fin)
                                : (neg_q_reg ? (32'd0 - quo_step) : quo_step);

  always_comb begin
    state_next  = state_reg;
    rem_next    = rem_reg;
    quo_next    = quo_reg;
    div_next    = div_reg;
    cnt_next    = cnt_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    is_rem_next = is_rem_reg;
    result_next = result_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          rem_next    = 33'd0;
          quo_next    = dvd_init;
          div_next    = abs_b;
          cnt_next    = iter_init;
          neg_q_next  = op_signed & (op_a_i[31] ^ op_b_i[31]);
          neg_r_next  = op_signed & op_a_i[31];
          is_rem_next = op_rem;
          if (b_zero) begin
            result_next = op_rem ? op_a_i : 32'hFFFF_FFFF;
            state_next  = DONE;
          end else if (sign_ovf) begin
            result_next = op_rem ? 32'd0 : 32'h8000_0000;
            state_next  = DONE;
          end else begin
            state_next  = CALC;
          end
        end
      end
      CALC: begin
        rem_next = rem_step;
        quo_next = quo_step;
        cnt_next = cnt_reg - 6'd1;
        if (cnt_reg == 6'd1) begin
          result_next = res_fin;
          state_next  = DONE;
        end
      end
      DONE: begin
        if (ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // A flush discards whatever is in flight, including a pending result.
    if (kill_i) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      rem_reg    <= 33'd0;
      quo_reg    <= 32'd0;
      div_reg    <= 32'd0;
      cnt_reg    <= 6'd0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      is_rem_reg <= 1'b0;
      result_reg <= 32'd0;
    end else begin
      state_reg  <= state_next;
      rem_reg    <= rem_next;
      quo_reg    <= quo_next;
      div_reg    <= div_next;
      cnt_reg    <= cnt_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      is_rem_reg <= is_rem_next;
      result_reg <= result_next;
    end
  end

  assign ready_o  = (state_reg == IDLE);
  assign valid_o  = (state_reg == DONE);
  assign result_o = result_reg;

endmodule
